// File: rtl/msk_add_wtk_sched.sv
// Masked tweakey / W-constant adder for the Clyde datapath, with internal tweak schedule and W LFSR.
// Optional per-transfer share refresh: define MSK_ADDWTK_REFRESH_EN (adds the rnd port).
module msk_add_wtk_sched #(
  parameter int              Nbits  = 128,
  parameter int              d      = 2,
  parameter int              ROWS   = Nbits / 32,
  parameter int              NTK    = 7,
  parameter logic [ROWS-1:0] W_INIT = {{(ROWS-1){1'b0}}, 1'b1},
  parameter logic [ROWS-1:0] W_TAPS = ROWS'(4'b1100)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic [Nbits-1:0]       tweak,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [d*Nbits-1:0]     sharing_bundle_in,
  input  logic [d*Nbits-1:0]     sharing_K,
`ifdef MSK_ADDWTK_REFRESH_EN
  input  logic [(d-1)*Nbits-1:0] rnd,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [d*Nbits-1:0]     sharing_bundle_out,
  output logic                   out_last
);

  localparam int CNT_W = $clog2(NTK + 1);
  localparam int HALF  = Nbits / 2;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic               w_in_ready;
  logic               w_xfer;
  logic               w_tk_last;
  logic [Nbits-1:0]   r_tweak;
  logic [CNT_W-1:0]   r_tk_cnt;
  logic [1:0]         r_phase;
  logic [ROWS-1:0]    r_lfsr;
  logic [ROWS-1:0]    w_lfsr_nxt;
  logic [HALF-1:0]    w_t1, w_t0;
  logic [Nbits-1:0]   w_delta;
  logic [d*Nbits-1:0] w_sum;
  logic [d*Nbits-1:0] r_out;
  logic               r_out_valid;
  logic               r_out_last;

  assign w_t1      = r_tweak[Nbits-1:HALF];
  assign w_t0      = r_tweak[HALF-1:0];
  assign w_tk_last = (r_tk_cnt == CNT_W'(NTK - 1));
  assign w_xfer    = in_valid && w_in_ready;

  // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        w_in_ready = !r_out_valid || out_ready;
        if (in_valid && w_in_ready && in_mode[0] && w_tk_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  generate
    if (ROWS > 1) begin : g_lfsr_shift
      assign w_lfsr_nxt = {r_lfsr[ROWS-2:0], ^(r_lfsr & W_TAPS)};
    end else begin : g_lfsr_single
      assign w_lfsr_nxt = ^(r_lfsr & W_TAPS);
    end
  endgenerate

  // 3-phase tweak schedule: the delta cycles through the three linear mixes of T1/T0.
  always_comb begin
    case (r_phase)
      2'd1:    w_delta = {w_t0, w_t0 ^ w_t1};
      2'd2:    w_delta = {w_t0 ^ w_t1, w_t1};
      default: w_delta = {w_t1, w_t0};
    endcase
  end

  // NOTE: blocking assignments here build the sum step by step inside one combinational
  // evaluation; registered state below uses non-blocking assignments only.
  always_comb begin
    w_sum = sharing_bundle_in;
    if (in_mode[0]) begin
      w_sum = w_sum ^ sharing_K;
      for (int j = 0; j < Nbits; j++) w_sum[d*j] = w_sum[d*j] ^ w_delta[j];
    end
    if (in_mode[1]) begin
      for (int r = 0; r < ROWS; r++) w_sum[d*32*r] = w_sum[d*32*r] ^ r_lfsr[r];
    end
`ifdef MSK_ADDWTK_REFRESH_EN
    // Each fresh bit lands on one leading share and on the last share, so the unmasked value is unchanged.
    for (int j = 0; j < Nbits; j++) begin
      for (int i = 0; i < d - 1; i++) w_sum[d*j+i] = w_sum[d*j+i] ^ rnd[(d-1)*j+i];
      w_sum[d*j+d-1] = w_sum[d*j+d-1] ^ (^rnd[(d-1)*j +: d-1]);
    end
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tweak  <= '0;
      r_tk_cnt <= '0;
      r_phase  <= 2'd0;
      r_lfsr   <= W_INIT;
    end else if (r_state == S_IDLE && start) begin
      r_tweak  <= tweak;
      r_tk_cnt <= '0;
      r_phase  <= 2'd0;
      r_lfsr   <= W_INIT;
    end else if (w_xfer) begin
      if (in_mode[0]) begin
        r_tk_cnt <= r_tk_cnt + CNT_W'(1);
        r_phase  <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
      end
      if (in_mode[1]) r_lfsr <= w_lfsr_nxt;
    end
  end

  // NOTE: the wide data register is reset as well, so an aborted run leaves no shares visible.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_xfer) begin
      r_out       <= w_sum;
      r_out_valid <= 1'b1;
      r_out_last  <= in_mode[0] && w_tk_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign busy               = (r_state == S_RUN);
  assign in_ready           = w_in_ready;
  assign out_valid          = r_out_valid;
  assign out_last           = r_out_last;
  assign sharing_bundle_out = r_out;

endmodule
